// File: rtl/ftoi_seq.sv
// Sequential float -> fixed-point integer converter: one shift bit per cycle,
// round-to-nearest-even, saturation with invalid/inexact flags, valid/ready on both sides.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exponent;
    logic [51:0] mantissa;
  } float64;
endpackage

module ftoi_seq #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$bits(float)-1:0] in,
  input  logic                    issigned,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width-1:0]        out,
  output logic                    flag_invalid,
  output logic                    flag_inexact
);

  float w_f;
  assign w_f = in;

  localparam int MBITS = $bits(w_f.mantissa);
  localparam int EBITS = $bits(w_f.exponent);
  localparam int BIAS  = 2 ** (EBITS - 1) - 1;
  localparam int M     = MBITS + 1;
  localparam int NMAX  = M + 2;
  localparam int CNTW  = $clog2(NMAX + 1);
  localparam int ACCW  = width + 1;

  localparam logic [width-1:0] SMAX   = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] SMIN   = {1'b1, {(width-1){1'b0}}};
  localparam logic [width+1:0] LIM_U  = {2'b00, {width{1'b1}}};
  localparam logic [width+1:0] LIM_SP = {3'b000, {(width-1){1'b1}}};
  localparam logic [width+1:0] LIM_SN = {3'b001, {(width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t            r_state, w_next;
  logic [ACCW-1:0]   r_acc;
  logic              r_guard, r_sticky;
  logic [CNTW-1:0]   r_cnt;
  logic              r_left, r_sign, r_signed;
  logic [width-1:0]  r_out;
  logic              r_inv, r_inex;

  function automatic logic [width-1:0] sat(input logic neg, input logic sgn);
    if (sgn) return neg ? SMIN : SMAX;
    return neg ? '0 : '1;
  endfunction

  // Operand decode, only consumed in the capture cycle
  int           w_e, w_shl, w_n;
  logic         w_special, w_zero, w_nan;
  logic [M-1:0] w_sig;

  always_comb begin
    w_nan     = (w_f.exponent == '1) && (w_f.mantissa != '0);
    w_zero    = (w_f.exponent == '0) && (w_f.mantissa == '0);
    w_e       = (w_f.exponent == '0) ? 1 - BIAS : int'(w_f.exponent) - BIAS;
    w_special = (w_f.exponent == '1) || (w_e + frac > width);
    w_shl     = w_e - MBITS + frac;
    w_n       = (w_shl < 0) ? -w_shl : w_shl;
    if (w_n > NMAX) w_n = NMAX;
    w_sig     = {(w_f.exponent != '0), w_f.mantissa};
  end

  // Rounding and range check; magnitude carries two extra bits so overflow is visible
  logic             w_inc, w_ovf, w_rinv, w_rinex;
  logic [width+1:0] w_m;
  logic [width-1:0] w_rout;

  always_comb begin
    w_inc   = r_guard && (r_sticky || r_acc[0]);
    w_m     = {1'b0, r_acc} + {{(width+1){1'b0}}, w_inc};
    w_rinex = r_guard || r_sticky;
    w_rinv  = 1'b0;
    if (r_signed) w_ovf = r_sign ? (w_m > LIM_SN) : (w_m > LIM_SP);
    else          w_ovf = r_sign ? (w_m != '0)    : (w_m > LIM_U);
    if (w_ovf) begin
      w_rout  = sat(r_sign, r_signed);
      w_rinv  = 1'b1;
      w_rinex = 1'b0;
    end else if (r_sign) begin
      w_rout = r_signed ? -w_m[width-1:0] : '0;
    end else begin
      w_rout = w_m[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_special || w_zero) w_next = DONE;
          else if (w_n == 0)       w_next = ROUND;
          else                     w_next = SHIFT;
        end
      end
      SHIFT:   if (r_cnt == CNTW'(1)) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_sign   <= 1'b0;
      r_signed <= 1'b0;
      r_out    <= '0;
      r_inv    <= 1'b0;
      r_inex   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign   <= w_f.sign;
            r_signed <= issigned;
            r_acc    <= ACCW'(w_sig);
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= CNTW'(w_n);
            r_left   <= (w_shl > 0);
            if (w_special) begin
              // NaN saturates toward +max whatever its sign bit
              r_out  <= sat(w_f.sign && !w_nan, issigned);
              r_inv  <= 1'b1;
              r_inex <= 1'b0;
            end else if (w_zero) begin
              r_out  <= '0;
              r_inv  <= 1'b0;
              r_inex <= 1'b0;
            end
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_left) begin
            r_acc <= {r_acc[ACCW-2:0], 1'b0};
          end else begin
            r_acc    <= r_acc >> 1;
            r_guard  <= r_acc[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        ROUND: begin
          r_out  <= w_rout;
          r_inv  <= w_rinv;
          r_inex <= w_rinex;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign out          = r_out;
  assign flag_invalid = r_inv;
  assign flag_inexact = r_inex;

endmodule

// File: tb/tb_ftoi_seq.sv
// Bench for ftoi_seq (float32 -> 32-bit integer): directed plan vectors, randomized
// operands against an arithmetic reference, backpressure, mid-flight reset, throughput.
module tb_ftoi_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_f = '0;
  logic        issigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_w;
  logic        flag_invalid, flag_inexact;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ftoi_seq #(.width(32), .frac(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_f),
    .issigned(issigned), .out_valid(out_valid), .out_ready(out_ready), .out(out_w),
    .flag_invalid(flag_invalid), .flag_inexact(flag_inexact)
  );

  typedef struct {
    logic [31:0] f;
    logic        sg;
    logic [31:0] o;
    logic        inv;
    logic        inex;
    int          lat;
  } vec_t;

  // Reference: exact value sig*2^(e-23), round half to even via quotient/remainder.
  function automatic void model(input logic [31:0] f, input logic sg, output logic [31:0] o,
                                output logic inv, output logic inex, output int lat);
    int ex, e, shl, k;
    logic s, neg;
    longint unsigned sig, m, q, rem, half;
    s    = f[31];
    ex   = int'(f[30:23]);
    o    = '0;
    inv  = 1'b0;
    inex = 1'b0;
    sig  = (ex != 0) ? (64'h800000 | 64'(f[22:0])) : 64'(f[22:0]);
    e    = (ex != 0) ? ex - 127 : -126;
    if (ex == 255 || e > 32) begin
      lat = 1;
      inv = 1'b1;
      neg = s && !(ex == 255 && f[22:0] != 0);
      o   = sg ? (neg ? 32'h80000000 : 32'h7FFFFFFF) : (neg ? 32'h0 : 32'hFFFFFFFF);
      return;
    end
    if (sig == 0) begin
      lat = 1;
      return;
    end
    shl = e - 23;
    k   = (shl < 0) ? -shl : shl;
    lat = ((k > 26) ? 26 : k) + 2;
    if (shl >= 0) begin
      m = sig << shl;
    end else if (k > 40) begin
      m    = 0;
      inex = 1'b1;
    end else begin
      q    = sig >> k;
      rem  = sig - (q << k);
      half = 64'd1 << (k - 1);
      m    = q;
      if (rem > half || (rem == half && q[0])) m = q + 1;
      inex = (rem != 0);
    end
    if (!sg) begin
      if (!s) begin
        if (m > 64'hFFFFFFFF) begin o = 32'hFFFFFFFF; inv = 1'b1; inex = 1'b0; end
        else o = m[31:0];
      end else if (m != 0) begin
        o = '0; inv = 1'b1; inex = 1'b0;
      end
    end else begin
      if (!s) begin
        if (m > 64'h7FFFFFFF) begin o = 32'h7FFFFFFF; inv = 1'b1; inex = 1'b0; end
        else o = m[31:0];
      end else if (m > 64'h80000000) begin
        o = 32'h80000000; inv = 1'b1; inex = 1'b0;
      end else begin
        o = -m[31:0];
      end
    end
  endfunction

  // Driver: called #1 after an edge with out_ready=1; returns result and latency.
  task automatic do_op(input logic [31:0] f, input logic sg, output logic [31:0] o,
                       output logic inv, output logic inex, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_f = f; issigned = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    o = out_w; inv = flag_invalid; inex = flag_inexact;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_w !== 32'h0 || flag_invalid !== 1'b0 || flag_inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b out=%h inv=%b inex=%b want v=0 out=0 inv=0 inex=0",
               out_valid, out_w, flag_invalid, flag_inexact);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    vec_t v[$];
    logic [31:0] o;
    logic inv, inex;
    int lat;
    v.push_back('{32'h40200000, 1'b1, 32'h00000002, 1'b0, 1'b1, 24});
    v.push_back('{32'h40600000, 1'b1, 32'h00000004, 1'b0, 1'b1, 24});
    v.push_back('{32'h3F800000, 1'b1, 32'h00000001, 1'b0, 1'b0, 25});
    v.push_back('{32'hBF800000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 25});
    v.push_back('{32'hBF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 25});
    v.push_back('{32'hBECCCCCD, 1'b0, 32'h00000000, 1'b0, 1'b1, 27});
    v.push_back('{32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 10});
    v.push_back('{32'h4F000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 10});
    v.push_back('{32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 10});
    v.push_back('{32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 10});
    v.push_back('{32'h7FC00000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
    v.push_back('{32'hFF800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1});
    v.push_back('{32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 28});
    v.push_back('{32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1});
    v.push_back('{32'h4F800000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 11});
    v.push_back('{32'hDF000000, 1'b1, 32'h80000000, 1'b1, 1'b0, 1});
    v.push_back('{32'hFFC00000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
    foreach (v[i]) begin
      do_op(v[i].f, v[i].sg, o, inv, inex, lat);
      checks++;
      if (o !== v[i].o) begin
        errors++;
        $display("FAIL dir_out f=%h s=%b: got %h want %h", v[i].f, v[i].sg, o, v[i].o);
      end
      checks++;
      if (inv !== v[i].inv) begin
        errors++;
        $display("FAIL dir_invalid f=%h s=%b: got %b want %b", v[i].f, v[i].sg, inv, v[i].inv);
      end
      checks++;
      if (inex !== v[i].inex) begin
        errors++;
        $display("FAIL dir_inexact f=%h s=%b: got %b want %b", v[i].f, v[i].sg, inex, v[i].inex);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL dir_latency f=%h s=%b: got %0d want %0d", v[i].f, v[i].sg, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] f, eo, go;
    logic sg, ei, ex, gi, gx;
    int el, gl;
    for (int n = 0; n < 300; n++) begin
      f  = $urandom;
      sg = 1'($urandom);
      if (n % 4 != 0) f[30:23] = 8'($urandom_range(100, 160));
      model(f, sg, eo, ei, ex, el);
      do_op(f, sg, go, gi, gx, gl);
      checks++;
      if (go !== eo) begin
        errors++;
        $display("FAIL rand_out f=%h s=%b: got %h want %h", f, sg, go, eo);
      end
      checks++;
      if (gi !== ei) begin
        errors++;
        $display("FAIL rand_invalid f=%h s=%b: got %b want %b", f, sg, gi, ei);
      end
      checks++;
      if (gx !== ex) begin
        errors++;
        $display("FAIL rand_inexact f=%h s=%b: got %b want %b", f, sg, gx, ex);
      end
      checks++;
      if (gl !== el) begin
        errors++;
        $display("FAIL rand_latency f=%h s=%b: got %0d want %0d", f, sg, gl, el);
      end
    end
  endtask

  task automatic test_backpressure;
    int w;
    out_ready = 1'b0;
    in_f = 32'h40600000; issigned = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    checks++;
    if (out_valid !== 1'b1 || out_w !== 32'd4 || flag_inexact !== 1'b1 || flag_invalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: got v=%b out=%h inv=%b inex=%b want v=1 out=4 inv=0 inex=1",
               out_valid, out_w, flag_invalid, flag_inexact);
    end
    for (int i = 0; i < 5; i++) begin
      in_f = $urandom; issigned = i[0]; in_valid = ~i[0];
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_w !== 32'd4 ||
          flag_inexact !== 1'b1 || flag_invalid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: got v=%b rdy=%b out=%h inv=%b inex=%b want v=1 rdy=0 out=4 inv=0 inex=1",
                 i, out_valid, in_ready, out_w, flag_invalid, flag_inexact);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    w = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) w++; end
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL bp_ignored: got %0d stray results want 0", w);
    end
  endtask

  task automatic test_reset_midflight;
    int w;
    logic [31:0] o;
    logic inv, inex;
    int lat;
    in_f = 32'h00000001; issigned = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got in_ready=%b want 0", in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_flight: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    w = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) w++; end
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL rst_stale: got %0d stale results want 0", w);
    end
    do_op(32'h3F800000, 1'b1, o, inv, inex, lat);
    checks++;
    if (o !== 32'd1 || inv !== 1'b0 || inex !== 1'b0 || lat !== 25) begin
      errors++;
      $display("FAIL rst_recover: got out=%h inv=%b inex=%b lat=%0d want out=1 inv=0 inex=0 lat=25",
               o, inv, inex, lat);
    end
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int outs = 0;
    int caps[$];
    in_f = 32'h3F800000; issigned = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    while (caps.size() < 3 && cyc < 200) begin
      if (in_ready) caps.push_back(cyc);
      if (out_valid) begin
        outs++;
        checks++;
        if (out_w !== 32'd1 || flag_invalid !== 1'b0 || flag_inexact !== 1'b0) begin
          errors++;
          $display("FAIL b2b_out: got out=%h inv=%b inex=%b want out=1 inv=0 inex=0",
                   out_w, flag_invalid, flag_inexact);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (caps.size() != 3 || outs != 2) begin
      errors++;
      $display("FAIL b2b_count: got caps=%0d outs=%0d want caps=3 outs=2", caps.size(), outs);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (caps[i] - caps[i-1] !== 26) begin
          errors++;
          $display("FAIL b2b_period: got %0d want 26", caps[i] - caps[i-1]);
        end
      end
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
